// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM/owner encodings and read-latency limits for the RAM port arbiter
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Which requester owns the RAM port
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

  // Supported RAM read latency range
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wait counter only needs to reach RD_LAT_MAX-1
  localparam int CNT_W = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant select; MEM_ARB_RR_EN selects round-robin tie-break
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  arb_owner_e last_grant_i,
  output logic       any_req_o,
  output arb_owner_e grant_o
);

`ifdef MEM_ARB_RR_EN
  // Tie goes to whoever was not granted last; a lone requester always wins
  always_comb begin
    any_req_o = if_req_i | d_req_i;
    grant_o   = OWN_DATA;
    if (if_req_i && d_req_i) begin
      grant_o = (last_grant_i == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (if_req_i) begin
      grant_o = OWN_FETCH;
    end
  end
`else
  // History is not needed when data always wins a tie
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: data first so the in-flight instruction can retire
  always_comb begin
    any_req_o = if_req_i | d_req_i;
    grant_o   = OWN_DATA;
    if (!d_req_i && if_req_i) begin
      grant_o = OWN_FETCH;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported RAM between fetch and load/store requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] data_i,
  output logic          busy_o
);

  // Reject unsupported read latencies at elaboration
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  arb_owner_e       last_grant_q, last_grant_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;

  logic             any_req;
  arb_owner_e       grant;
  logic             finish;
  logic             capture;

  mem_arb_pick u_pick (
    .if_req_i     (if_req_i),
    .d_req_i      (d_req_i),
    .last_grant_i (last_grant_q),
    .any_req_o    (any_req),
    .grant_o      (grant)
  );

  // Next-state, RAM port drive, ack and read-data capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    store_d      = store_q;
    cnt_d        = cnt_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    finish       = 1'b0;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_ACCESS;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          if (grant == OWN_DATA) begin
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            we_d    = d_we_i;
            store_d = d_we_i;
          end else begin
            addr_d  = if_addr_i;
            store_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (store_q) begin
          finish = 1'b1;
        end else if (RD_LAT == 1) begin
          finish  = 1'b1;
          capture = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering DONE: raise the owner's ack and latch load data together
    if (finish) begin
      state_d = ST_DONE;
      cnt_d   = '0;
      if (owner_q == OWN_FETCH) begin
        if_ack_d = 1'b1;
      end else begin
        d_ack_d = 1'b1;
      end
    end
    if (capture) begin
      if (owner_q == OWN_FETCH) begin
        if_rdata_d = data_i;
      end else begin
        d_rdata_d = data_i;
      end
    end
  end

  // State and port registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_FETCH;
      store_q      <= 1'b0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      store_q      <= store_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign if_ack_o   = if_ack_q;
  assign d_ack_o    = d_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural RAM and scoreboard
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] data_i;
  logic          busy_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_ack_o    (d_ack_o),
    .d_rdata_o  (d_rdata_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .data_i     (data_i),
    .busy_o     (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] hist    [LAT];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_d_rd;
  bit          mdl_last_data;
  bit          dual_ack_seen;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic bit tie_to_data();
`ifdef MEM_ARB_RR_EN
    return !mdl_last_data;
`else
    return 1'b1;
`endif
  endfunction

  // RAM: writes land when we_o is high; reads return the word addressed LAT-1 cycles earlier
  always @(negedge clk) begin
    if (we_o) ram[addr_o] = wdata_o;
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = addr_o;
    data_i = ram.exists(hist[LAT-1]) ? ram[hist[LAT-1]] : init_word(hist[LAT-1]);
    if (if_ack_o && d_ack_o) dual_ack_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One lone request, checked for latency, RAM write pulse and returned data
  task automatic txn(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    int wcnt = 0;
    bit got = 0;
    bit other = 0;
    int lat_exp;
    logic [31:0] wa = '0;
    logic [31:0] wv = '0;
    chk("idle_before", {31'b0, busy_o}, 32'd0);
    if (is_d) begin
      d_req_i = 1; d_we_i = we; d_addr_i = a; d_wdata_i = wd;
    end else begin
      if_req_i = 1; if_addr_i = a;
    end
    lat_exp = (is_d && we) ? 2 : LAT + 1;
    while (!got && n < 20) begin
      tick();
      n++;
      if (we_o) begin wcnt++; wa = addr_o; wv = wdata_o; end
      if (is_d ? if_ack_o : d_ack_o) other = 1;
      if (is_d ? d_ack_o : if_ack_o) got = 1;
    end
    if_req_i = 0;
    d_req_i  = 0;
    mdl_last_data = is_d;
    chk("ack_seen", {31'b0, got}, 32'd1);
    chk("ack_latency", n, lat_exp);
    chk("wrong_ack", {31'b0, other}, 32'd0);
    chk("we_pulses", wcnt, (is_d && we) ? 1 : 0);
    if (is_d && we) begin
      chk("store_addr", wa, a);
      chk("store_data", wv, wd);
      ref_mem[a] = wd;
    end else if (is_d) begin
      exp_d_rd = ref_rd(a);
    end else begin
      exp_if_rd = ref_rd(a);
    end
    chk("if_rdata", if_rdata_o, exp_if_rd);
    chk("d_rdata", d_rdata_o, exp_d_rd);
    tick();
    chk("ack_one_cycle", {30'b0, if_ack_o, d_ack_o}, 32'd0);
    chk("idle_after", {31'b0, busy_o}, 32'd0);
  endtask

  // Both requesters raise together; each drops its request on its own ack
  task automatic tie(input logic [31:0] fa, input logic [31:0] da, input bit dwe, input logic [31:0] dwd);
    bit first_d;
    int lat_d, lat_f, n_first, n_second;
    int n = 0;
    int nd = 0;
    int nf = 0;
    bit gd = 0;
    bit gf = 0;
    first_d  = tie_to_data();
    lat_d    = dwe ? 2 : LAT + 1;
    lat_f    = LAT + 1;
    n_first  = first_d ? lat_d : lat_f;
    n_second = n_first + 1 + (first_d ? lat_f : lat_d);
    if_req_i = 1; if_addr_i = fa;
    d_req_i = 1; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd;
    while (!(gd && gf) && n < 40) begin
      tick();
      n++;
      if (d_ack_o && !gd) begin gd = 1; nd = n; d_req_i = 0; end
      if (if_ack_o && !gf) begin gf = 1; nf = n; if_req_i = 0; end
    end
    if_req_i = 0;
    d_req_i  = 0;
    chk("tie_d_cycle", nd, first_d ? n_first : n_second);
    chk("tie_f_cycle", nf, first_d ? n_second : n_first);
    mdl_last_data = !first_d;
    if (dwe) ref_mem[da] = dwd;
    else exp_d_rd = ref_rd(da);
    exp_if_rd = ref_rd(fa);
    chk("tie_if_rdata", if_rdata_o, exp_if_rd);
    chk("tie_d_rdata", d_rdata_o, exp_d_rd);
    tick();
  endtask

  initial begin
    int n, acks, k, exp_n;
    bit is_d, we;
    logic [31:0] a, wd;

    reset = 1; if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0;
    d_addr_i = '0; d_wdata_i = '0; data_i = '0; dual_ack_seen = 0;
    exp_if_rd = '0; exp_d_rd = '0; mdl_last_data = 0;
    for (int i = 0; i < LAT; i++) hist[i] = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_we", {31'b0, we_o}, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_acks", {30'b0, if_ack_o, d_ack_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    reset = 0;
    tick();

    ram[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    txn(0, 0, 32'h40, '0);
    chk("fetch_word", if_rdata_o, 32'hDEAD_BEEF);
    txn(1, 1, 32'h100, 32'h1234_5678);
    txn(1, 0, 32'h100, '0);
    chk("load_back", d_rdata_o, 32'h1234_5678);

    tie(32'h44, 32'h100, 0, '0);
    tie(32'h48, 32'h104, 1, 32'hCAFE_F00D);

    // Both held high across four grants
    if_req_i = 1; if_addr_i = 32'h4C;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h104;
    n = 0; k = 0; exp_n = LAT + 1;
    while (k < 4 && n < 60) begin
      tick();
      n++;
      if (if_ack_o || d_ack_o) begin
        is_d = tie_to_data();
        mdl_last_data = is_d;
        chk("hold_owner", {31'b0, d_ack_o}, {31'b0, is_d});
        chk("hold_cycle", n, exp_n);
        if (is_d) exp_d_rd = ref_rd(32'h104);
        else exp_if_rd = ref_rd(32'h4C);
        exp_n += LAT + 2;
        k++;
      end
    end
    if_req_i = 0;
    d_req_i  = 0;
    chk("hold_count", k, 4);
    chk("hold_d_rdata", d_rdata_o, exp_d_rd);
    chk("hold_if_rdata", if_rdata_o, exp_if_rd);
    tick();

    // Data request withdrawn mid-read still completes exactly once
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h40;
    n = 0; acks = 0; exp_n = 0; k = 0;
    while (n < 10) begin
      tick();
      n++;
      if (n == 2) d_req_i = 0;
      if (d_ack_o) begin acks++; exp_n = n; end
      if (we_o) k++;
    end
    mdl_last_data = 1;
    exp_d_rd = ref_rd(32'h40);
    chk("drop_acks", acks, 1);
    chk("drop_cycle", exp_n, LAT + 1);
    chk("drop_we", k, 0);
    chk("drop_busy", {31'b0, busy_o}, 32'd0);
    chk("drop_rdata", d_rdata_o, exp_d_rd);
    chk("drop_addr_kept", addr_o, 32'h40);

    // Reset while a load waits on the RAM
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
    tick();
    tick();
    reset = 1; d_req_i = 0;
    tick();
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_ack", {31'b0, d_ack_o}, 32'd0);
    chk("midrst_addr", addr_o, 32'd0);
    chk("midrst_d_rdata", d_rdata_o, 32'd0);
    reset = 0;
    exp_if_rd = '0; exp_d_rd = '0; mdl_last_data = 0;
    tick();
    chk("postrst_ack", {31'b0, d_ack_o}, 32'd0);
    txn(1, 0, 32'h44, '0);

    // Random lone requests over a small address pool
    for (int i = 0; i < 40; i++) begin
      is_d = $urandom_range(0, 1);
      we   = is_d && ($urandom_range(0, 2) == 0);
      a    = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      wd   = $urandom;
      txn(is_d, we, a, wd);
    end

    chk("no_dual_ack", {31'b0, dual_ack_seen}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
